// File: rtl/core_pkg.sv
// Shared RV32 core types: widths, ALUOp encodings, control bundle.
// Used by the ID/EX register and its hazard detector.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       ALUSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       Branch;
    logic [1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t gate_ctrl(
    input ctrl_t c,
    input logic  v
  );
    return v ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the operands in ID.
// Suppressed while the pipe is held or squashed.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              stall,
  input  logic              flush,
  output logic              load_use_stall
);

  logic rd_nz;
  logic hit;

  always_comb begin
    rd_nz = |ex_rd;
    hit   = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    load_use_stall = ex_valid & ex_mem_read & rd_nz
                   & id_valid & hit
                   & ~stall & ~flush;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional ID_EX_BUBBLE_CNT_EN adds a load-use bubble counter.
module id_ex_reg
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_funct7_bit_6,
  input  logic [2:0]        id_funct3,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_ALUSrc,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_Branch,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_funct7_bit_6,
  output logic [2:0]        ex_funct3,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_ALUSrc,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_Branch,
  output logic              load_use_stall
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_count
`endif
);

  ctrl_t id_ctrl;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              f7_q, f7_d;
  logic [2:0]        f3_q, f3_d;
  ctrl_t             ctrl_q, ctrl_d;

  logic bubble;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lud (
    .ex_valid      (valid_q),
    .ex_mem_read   (ctrl_q.MemRead),
    .ex_rd         (rd_q),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .stall         (stall),
    .flush         (flush),
    .load_use_stall(load_use_stall)
  );

  always_comb begin
    id_ctrl          = CTRL_NOP;
    id_ctrl.ALUSrc   = id_ALUSrc;
    id_ctrl.MemRead  = id_MemRead;
    id_ctrl.MemWrite = id_MemWrite;
    id_ctrl.RegWrite = id_RegWrite;
    id_ctrl.MemtoReg = id_MemtoReg;
    id_ctrl.Branch   = id_Branch;
    id_ctrl.ALUOp    = id_ALUOp;
  end

  // load_use_stall is already masked by stall/flush
  assign bubble = flush | load_use_stall;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    f7_d       = f7_q;
    f3_d       = f3_q;
    ctrl_d     = ctrl_q;
    if (bubble) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      f7_d       = 1'b0;
      f3_d       = '0;
      ctrl_d     = CTRL_NOP;
    end else if (!stall) begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      f7_d       = id_funct7_bit_6;
      f3_d       = id_funct3;
      ctrl_d     = gate_ctrl(id_ctrl, id_valid);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      f7_q       <= 1'b0;
      f3_q       <= '0;
      ctrl_q     <= CTRL_NOP;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      f7_q       <= f7_d;
      f3_q       <= f3_d;
      ctrl_q     <= ctrl_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_use_stall) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bubble_count = cnt_q;
`endif

  assign ex_valid        = valid_q;
  assign ex_pc           = pc_q;
  assign ex_rs1_data     = rs1_data_q;
  assign ex_rs2_data     = rs2_data_q;
  assign ex_imm          = imm_q;
  assign ex_rs1          = rs1_q;
  assign ex_rs2          = rs2_q;
  assign ex_rd           = rd_q;
  assign ex_funct7_bit_6 = f7_q;
  assign ex_funct3       = f3_q;
  assign ex_ALUOp        = ctrl_q.ALUOp;
  assign ex_ALUSrc       = ctrl_q.ALUSrc;
  assign ex_MemRead      = ctrl_q.MemRead;
  assign ex_MemWrite     = ctrl_q.MemWrite;
  assign ex_RegWrite     = ctrl_q.RegWrite;
  assign ex_MemtoReg     = ctrl_q.MemtoReg;
  assign ex_Branch       = ctrl_q.Branch;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline register for the 5-stage RV32 core. It captures decoded operands, immediates, register addresses, funct fields and control bits from ID, and presents them to EX (ALU control, ALU, forwarding) one cycle later. It also owns load-use hazard detection: it inserts a bubble into EX and asserts a stall request back to PC/IF-ID. It supports external hold (stall) and branch flush.

Parameters:
XLEN, 32, datapath width of PC, operands, immediate
REG_AW, 5, register-address width

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  external hold from downstream; freeze all outputs
flush  in  1  branch-taken squash; load bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_AW  register addresses
id_funct7_bit_6  in  1  instr[30]
id_funct3  in  3  instr[14:12]
id_ALUOp  in  2  00 add, 01 sub/branch, 10 R-type
id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch  in  1 each  control bits
ex_*  out  (same widths)  registered copies of every id_* input above, including ex_valid
load_use_stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (reset_n=0, async): all ex_* outputs = 0. ex_ALUOp = 2'b00, ex_valid = 0. Reset is effective mid-operation and overrides everything.
- Hazard (combinational): load_use_stall = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)). It is forced to 0 when stall=1 or flush=1.
- Per-edge priority: flush > stall > load_use_stall > normal load.
  - flush=1: load a bubble. Flush beats stall in the same cycle.
  - stall=1 (flush=0): every ex_* output holds its value, and no hazard bubble is inserted.
  - load_use_stall=1: load a bubble. ID contents are not lost, because IF/ID holds them and they reload on the next edge.
  - Otherwise: ex_* <= id_*. Latency is exactly 1 cycle.
- Bubble: ex_valid=0, all six control bits 0, ex_ALUOp=00, all data, address and funct fields 0.
- id_valid=0 with a normal load: fields load as presented, but ex_valid=0 and control bits are gated to 0.
- Back-to-back loads: the hazard is evaluated against the current EX contents only. After a one-cycle bubble the load has moved to MEM, so the hazard clears; forwarding covers MEM->EX.
- rd=x0: never raises a hazard.
- No combinational path from id_* to ex_*. load_use_stall depends only on registered EX state and id_rs1/id_rs2/id_valid/stall/flush.

Optional Feature:
ID_EX_BUBBLE_CNT_EN:
- Defined: adds output bubble_count [31:0].
  - Reset to 0.
  - Increments by 1 on each edge where a load-use bubble is inserted; flush bubbles are not counted.
  - Holds during stall.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - XLEN and REG_AW constants.
  - ALUOp encodings: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10.
  - A packed ctrl_t struct with fields ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, ALUOp, and a CTRL_NOP constant of all zeros.
- One sub-module, load_use_detect, holds the pure combinational hazard compare. The register bank stays in the top.

Test Plan:
- Reset: assert reset_n=0 asynchronously between edges -> all ex_* and load_use_stall are 0 immediately.
- Pass-through: id_pc=0x100, id_rd=5, id_funct3=3'b111, id_ALUOp=10, id_RegWrite=1, id_valid=1 -> next edge ex_pc=0x100, ex_rd=5, ex_funct3=7, ex_ALUOp=10, ex_valid=1.
- Load-use: EX holds lw (MemRead=1, rd=7, valid=1), ID has rs2=7 -> load_use_stall=1, next edge is a bubble (ex_valid=0, controls 0). On the following edge the ID instruction loads, and bubble_count=1 when the macro is defined.
- rd=x0: EX holds lw with rd=0, ID has rs1=0 -> load_use_stall=0, normal load.
- Stall/flush priority:
  - stall=1 for 3 cycles with changing id_* -> ex_* are constant.
  - stall=1 and flush=1 together -> bubble loads.
  - stall=1 during a load-use condition -> load_use_stall=0 and EX holds.
- Flush: a valid add in ID with flush=1 -> ex_valid=0, ex_RegWrite=0, ex_ALUOp=00, and bubble_count is unchanged.
